// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: word width, address width, word type and the
// drain-stage state encoding used by fifo_drain_stream.
package fifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;

    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } drain_state_e;

endpackage

// File: rtl/fifo_drain_obuf.sv
// Small circular output buffer for the drain stage. The head word is read
// combinationally so the stream can present it in the same cycle; with only
// 2..4 entries this stays in fabric registers.
module fifo_drain_obuf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int OBUF_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_wr,
    input  logic [DATA_WIDTH-1:0]             i_wr_data,
    input  logic                              i_rd,
    output logic [DATA_WIDTH-1:0]             o_head,
    output logic [$clog2(OBUF_DEPTH+1)-1:0]   o_occ
);

    localparam int PTR_W = (OBUF_DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = $clog2(OBUF_DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [OBUF_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_occ;

    // Storage write at the write pointer; contents need no reset because
    // occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (i_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap at OBUF_DEPTH, which
    // need not be a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_wr) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(OBUF_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (i_rd) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(OBUF_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({i_wr, i_rd})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_drain_stream.sv
// Drain stage between the FIFO and a valid/ready consumer. Issues pops only
// when the output buffer can absorb every word already in flight, captures
// the FIFO's registered read data one cycle after each pop and streams it.
// Optional statistics counters are built when FIFO_DRAIN_STATS_EN is defined.
module fifo_drain_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int OBUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic                  fifo_push,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_pop,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [15:0]           words_out,
    output logic [15:0]           stall_cycles
`endif
);

    localparam int CNT_W = $clog2(OBUF_DEPTH + 1);

    drain_state_e          r_state;
    drain_state_e          w_state_next;
    logic                  r_inflight;
    logic [CNT_W-1:0]      w_occ;
    logic [DATA_WIDTH-1:0] w_head;
    logic [CNT_W:0]        w_outstanding;
    logic                  w_credit;
    logic                  w_buf_nonempty;
    logic                  w_bypass;
    logic                  w_take;
    logic                  w_buf_wr;
    logic                  w_buf_rd;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: STOP waits for the last issued pop to land before
    // returning to IDLE, but re-enabling resumes RUN immediately.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (en) w_state_next = RUN;
            RUN:     if (!en) w_state_next = STOP;
            STOP: begin
                if (en) begin
                    w_state_next = RUN;
                end else if (!r_inflight) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // A pop is allowed only if the buffer can hold every word it already
    // holds plus the one in flight plus this one. A push in the same cycle
    // would make the FIFO ignore the pop, so none is issued then.
    assign w_outstanding = {1'b0, w_occ} + {{CNT_W{1'b0}}, r_inflight};
    assign w_credit      = w_outstanding < (CNT_W+1)'(OBUF_DEPTH);
    assign fifo_pop      = (r_state == RUN) && !fifo_empty && !fifo_push && w_credit;

    // The FIFO's read data is valid the cycle after a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_pop;
        end
    end

    // When the buffer is empty the landing word is shown directly; if the
    // consumer takes it straight away it never enters the buffer.
    assign w_buf_nonempty = (w_occ != '0);
    assign w_bypass       = r_inflight && !w_buf_nonempty;
    assign m_valid        = w_buf_nonempty || r_inflight;
    assign m_data         = w_buf_nonempty ? w_head :
                            (r_inflight ? fifo_data_out : '0);
    assign w_take         = m_valid && m_ready;
    assign w_buf_wr       = r_inflight && !(w_bypass && m_ready);
    assign w_buf_rd       = w_take && w_buf_nonempty;
    assign busy           = (r_state != IDLE) || r_inflight || w_buf_nonempty;

    fifo_drain_obuf #(
        .DATA_WIDTH (DATA_WIDTH),
        .OBUF_DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .i_wr      (w_buf_wr),
        .i_wr_data (fifo_data_out),
        .i_rd      (w_buf_rd),
        .o_head    (w_head),
        .o_occ     (w_occ)
    );

`ifdef FIFO_DRAIN_STATS_EN
    logic [15:0] r_words_out;
    logic [15:0] r_stall_cycles;

    // Saturating counters of delivered words and consumer stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_words_out    <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_take && (r_words_out != 16'hFFFF)) begin
                r_words_out <= r_words_out + 16'd1;
            end
            if (m_valid && !m_ready && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    assign words_out    = r_words_out;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule
